// File: rtl/cbb_ram_pkg.sv
// Shared definitions for the common-building-block RAMs: read-during-write modes,
// the zero-fill FSM state encoding and the byte-enable width helper.
package cbb_ram_pkg;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  function automatic int unsigned BE_WIDTH(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Reset-free byte-lane storage with one byte-enabled write port and one registered
// read port; read returns the pre-write word on a same-address collision.
module sdp_ram_core
  import cbb_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned BeW   = BE_WIDTH(DATA_WIDTH);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BeW; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/simple_dp_ram_pipe.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read pipeline, defined
// read-during-write result and an optional post-reset zero-fill sequencer.
module simple_dp_ram_pipe
  import cbb_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = RDW_NEW,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int unsigned BeW = BE_WIDTH(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
  localparam ram_state_e StReset = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (RDW_MODE > RDW_NEW) begin : g_bad_rdw
    $error("RDW_MODE must be 0 or 1");
  end

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [BeW-1:0]        mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_acc;
  logic                  collide;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  s1_valid_q;
  logic [BeW-1:0]        col_be_q;
  logic [DATA_WIDTH-1:0] col_data_q;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReset;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
    endcase
  end

  // During zero-fill the clear counter owns the write port and requests are dropped.
  always_comb begin
    init_busy = 1'b0;
    mem_be    = '0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    rd_acc    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        init_busy = 1'b1;
        mem_be    = '1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
      end
      ST_READY: begin
        mem_be = wr_en ? wr_be : '0;
        rd_acc = rd_en;
      end
    endcase
  end

  assign collide = rd_acc & wr_en & (rd_addr == wr_addr);

  sdp_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .wr_be  (mem_be),
    .wr_addr(mem_addr),
    .wr_data(mem_wdata),
    .rd_en  (rd_acc),
    .rd_addr(rd_addr),
    .rd_data(core_rdata)
  );

  // Colliding write lanes are captured alongside the read so stage 1 can merge them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      col_be_q   <= '0;
      col_data_q <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        col_be_q   <= collide ? wr_be : '0;
        col_data_q <= wr_data;
      end
    end
  end

  always_comb begin
    s1_data = core_rdata;
    if (RDW_MODE == RDW_NEW) begin
      for (int i = 0; i < BeW; i++) begin
        if (col_be_q[i]) begin
          s1_data[8*i +: 8] = col_data_q[8*i +: 8];
        end
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    // The array output register has no reset, so mask it until a read has landed.
    logic seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        seen_q <= 1'b0;
      end else if (rd_acc) begin
        seen_q <= 1'b1;
      end
    end

    assign rd_valid = s1_valid_q;
    assign rd_data  = seen_q ? s1_data : '0;
  end else begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data;
        end
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end

endmodule
